// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/control slice: opcodes, PC-source encodings,
// fetch FSM states and instruction field positions. PC_FETCH_HALT_EN adds the HALTED state.
package cpu_pkg;

    localparam logic [3:0] OP_JUMP = 4'b1011;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam logic [1:0] SRC_INC = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JMP = 2'b10;

    localparam int CODOP_W  = 4;
    localparam int OFFSET_W = 8;

`ifdef PC_FETCH_HALT_EN
    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_WAIT_CTL,
        ST_UPDATE,
        ST_HALTED
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_WAIT_CTL,
        ST_UPDATE
    } fetch_state_e;
`endif

    // MSB of the opcode field for a given instruction width.
    function automatic int codop_msb(input int instr_width);
        return instr_width - 1;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: increment, PC-relative branch or absolute jump.
// All arithmetic wraps modulo 2^PC_WIDTH.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 8,
    parameter int LOW_W    = (PC_WIDTH > OFFSET_W) ? PC_WIDTH : OFFSET_W
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [LOW_W-1:0]    instr_i,
    input  logic                esccp_i,
    input  logic                esccondcp_i,
    input  logic [1:0]          fontecp_i,
    input  logic                zero_i,
    output logic [PC_WIDTH-1:0] next_pc_o
);

    logic [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_br;
    logic [PC_WIDTH-1:0] pc_jmp;

    // Sign-extend (or truncate, for narrow PCs) the 8-bit branch offset.
    generate
        for (genvar gi = 0; gi < PC_WIDTH; gi++) begin : g_sext
            if (gi < OFFSET_W) begin : g_low
                assign off_ext[gi] = instr_i[gi];
            end else begin : g_high
                assign off_ext[gi] = instr_i[OFFSET_W-1];
            end
        end
    endgenerate

    assign pc_inc = pc_i + PC_WIDTH'(1);
    assign pc_br  = pc_inc + off_ext;
    assign pc_jmp = instr_i[PC_WIDTH-1:0];

    always_comb begin
        next_pc_o = pc_inc;
        if (esccp_i) begin
            case (fontecp_i)
                SRC_JMP: next_pc_o = pc_jmp;
                SRC_BR:  next_pc_o = pc_br;
                default: next_pc_o = pc_inc;
            endcase
        end else if (esccondcp_i && zero_i && (fontecp_i == SRC_BR)) begin
            next_pc_o = pc_br;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Multi-cycle PC/fetch unit: FETCH -> DECODE -> WAIT_CTL -> UPDATE, one instruction in flight.
// Define PC_FETCH_HALT_EN to make opcode 4'b1111 halt the unit and expose halted_o.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    output logic                   imem_req_o,
    input  logic                   imem_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic [CODOP_W-1:0]     codop_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   instr_valid_o,
    input  logic                   esccondcp_i,
    input  logic                   esccp_i,
    input  logic [1:0]             fontecp_i,
    input  logic                   zero_i,
    output logic [PC_WIDTH-1:0]    pc_o
`ifdef PC_FETCH_HALT_EN
    ,
    output logic                   halted_o
`endif
);

    localparam int LOW_W = (PC_WIDTH > OFFSET_W) ? PC_WIDTH : OFFSET_W;
    localparam int CODOP_MSB = codop_msb(INSTR_WIDTH);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   req_q, req_d;
    logic [PC_WIDTH-1:0]    next_pc;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH),
        .LOW_W    (LOW_W)
    ) u_next_calc (
        .pc_i        (pc_q),
        .instr_i     (instr_q[LOW_W-1:0]),
        .esccp_i     (esccp_i),
        .esccondcp_i (esccondcp_i),
        .fontecp_i   (fontecp_i),
        .zero_i      (zero_i),
        .next_pc_o   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_d   = req_q;
        case (state_q)
            ST_FETCH: begin
                // Data is only taken once the request is actually on the bus.
                if (req_q && imem_valid_i) begin
                    instr_d = imem_rdata_i;
                    req_d   = 1'b0;
                    state_d = ST_DECODE;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_DECODE: begin
`ifdef PC_FETCH_HALT_EN
                if (instr_q[CODOP_MSB -: CODOP_W] == OP_NOP) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_WAIT_CTL;
                end
`else
                state_d = ST_WAIT_CTL;
`endif
            end
            ST_WAIT_CTL: state_d = ST_UPDATE;
            ST_UPDATE: begin
                // Raise the next request together with the PC update to keep a 4-cycle period.
                pc_d    = next_pc;
                req_d   = 1'b1;
                state_d = ST_FETCH;
            end
`ifdef PC_FETCH_HALT_EN
            ST_HALTED: begin
                req_d   = 1'b0;
                state_d = ST_HALTED;
            end
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    assign imem_addr_o   = pc_q;
    assign imem_req_o    = req_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign codop_o       = instr_q[CODOP_MSB -: CODOP_W];
    assign instr_valid_o = (state_q == ST_DECODE) || (state_q == ST_WAIT_CTL) ||
                           (state_q == ST_UPDATE);
`ifdef PC_FETCH_HALT_EN
    assign halted_o      = (state_q == ST_HALTED);
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed cases from the plan plus randomized
// instructions checked against a transaction-level next-PC model.
module tb_pc_fetch_unit;

    localparam int PCW = 8;
    localparam int IW  = 16;
    localparam int PC_MOD = 1 << PCW;

    logic           clk;
    logic           rst_n;
    logic [PCW-1:0] imem_addr_o;
    logic           imem_req_o;
    logic           imem_valid_i;
    logic [IW-1:0]  imem_rdata_i;
    logic [3:0]     codop_o;
    logic [IW-1:0]  instr_o;
    logic           instr_valid_o;
    logic           esccondcp_i;
    logic           esccp_i;
    logic [1:0]     fontecp_i;
    logic           zero_i;
    logic [PCW-1:0] pc_o;
`ifdef PC_FETCH_HALT_EN
    logic           halted_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int model_pc = 0;
    int latch_cyc = 0;
    logic [IW-1:0] cur_word;

    pc_fetch_unit #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr_o   (imem_addr_o),
        .imem_req_o    (imem_req_o),
        .imem_valid_i  (imem_valid_i),
        .imem_rdata_i  (imem_rdata_i),
        .codop_o       (codop_o),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .esccondcp_i   (esccondcp_i),
        .esccp_i       (esccp_i),
        .fontecp_i     (fontecp_i),
        .zero_i        (zero_i),
        .pc_o          (pc_o)
`ifdef PC_FETCH_HALT_EN
        ,
        .halted_o      (halted_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference next-PC rule, computed with plain modular integer arithmetic.
    function automatic int ref_next(input int pc, input logic [15:0] w, input bit ucp,
                                    input bit ccp, input logic [1:0] src, input bit z);
        int inc, off, br, jmp;
        inc = (pc + 1) % PC_MOD;
        off = int'(w[7:0]);
        if (off >= 128) off = off - 256;
        br  = (pc + 1 + off + 4 * PC_MOD) % PC_MOD;
        jmp = int'(w) % PC_MOD;
        if (ucp) begin
            if (src == 2'd2) return jmp;
            if (src == 2'd1) return br;
            return inc;
        end
        if (ccp && z && src == 2'd1) return br;
        return inc;
    endfunction

    // Starts at a negedge; ends at the negedge where the DUT sits in DECODE.
    task automatic fetch_phase(input logic [15:0] word, input int stall);
        int waited = 0;
        while (imem_req_o !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen", imem_req_o, 1'b1);
        check("fetch_addr", imem_addr_o, model_pc);
        imem_valid_i = 1'b0;
        for (int i = 0; i < stall; i++) begin
            imem_rdata_i = $urandom;
            @(negedge clk);
            check("stall_req", imem_req_o, 1'b1);
            check("stall_addr", imem_addr_o, model_pc);
        end
        imem_valid_i = 1'b1;
        imem_rdata_i = word;
        cur_word = word;
        @(negedge clk);
        latch_cyc = cyc;
        check("dec_ivalid", instr_valid_o, 1'b1);
        check("dec_codop", codop_o, word[15:12]);
        check("dec_req", imem_req_o, 1'b0);
        // Traffic outside FETCH must be ignored.
        imem_valid_i = 1'($urandom);
        imem_rdata_i = $urandom;
    endtask

    // Starts in DECODE; ends at the negedge where the DUT is back in FETCH.
    task automatic finish_phase(input bit ucp, input bit ccp, input logic [1:0] src, input bit z);
        int exp_pc;
        esccp_i = ucp;
        esccondcp_i = ccp;
        fontecp_i = src;
        zero_i = 1'($urandom);
        @(negedge clk);
        check("wait_ivalid", instr_valid_o, 1'b1);
        zero_i = z;
        @(negedge clk);
        check("upd_instr", instr_o, cur_word);
        check("upd_pc_hold", pc_o, model_pc);
        imem_valid_i = 1'b0;
        @(negedge clk);
        exp_pc = ref_next(model_pc, cur_word, ucp, ccp, src, z);
        check("next_pc", pc_o, exp_pc);
        check("exit_ivalid", instr_valid_o, 1'b0);
        check("refetch_req", imem_req_o, 1'b1);
        $display("txn pc=%02h instr=%04h esccp=%0b esccondcp=%0b src=%0d zero=%0b next=%02h",
                 model_pc, cur_word, ucp, ccp, src, z, pc_o);
        model_pc = exp_pc;
        esccp_i = 1'b0;
        esccondcp_i = 1'b0;
        fontecp_i = 2'b00;
    endtask

    task automatic run_instr(input logic [15:0] word, input int stall, input bit ucp,
                             input bit ccp, input logic [1:0] src, input bit z);
        fetch_phase(word, stall);
        finish_phase(ucp, ccp, src, z);
    endtask

    task automatic jump_to(input int target);
        logic [15:0] w;
        w = 16'hB000 | 16'(target);
        run_instr(w, 0, 1'b1, 1'b0, 2'b10, 1'b0);
    endtask

    // Called at a negedge; asserts reset between edges and checks it takes effect at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        imem_valid_i = 1'b0;
        esccp_i = 1'b0;
        esccondcp_i = 1'b0;
        fontecp_i = 2'b00;
        #1;
        check("rst_pc", pc_o, 0);
        check("rst_codop", codop_o, 0);
        check("rst_ivalid", instr_valid_o, 1'b0);
        check("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_pc = 0;
    endtask

    initial begin
        int t0, t1, t2;
        logic [15:0] w;
        logic [1:0] src;
        bit ucp, ccp;
        rst_n = 1'b0;
        imem_valid_i = 1'b0;
        imem_rdata_i = '0;
        esccondcp_i = 1'b0;
        esccp_i = 1'b0;
        fontecp_i = 2'b00;
        zero_i = 1'b0;
        cur_word = '0;
        repeat (2) @(negedge clk);
        check("init_pc", pc_o, 0);
        check("init_req", imem_req_o, 1'b0);
        check("init_ivalid", instr_valid_o, 1'b0);
        check("init_instr", instr_o, 0);
`ifdef PC_FETCH_HALT_EN
        check("init_halted", halted_o, 1'b0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", imem_req_o, 1'b1);

        // Sequential fetch at 4-cycle spacing
        run_instr(16'h1000, 0, 0, 0, 2'b00, 0);
        t0 = latch_cyc;
        run_instr(16'h1234, 0, 0, 0, 2'b00, 0);
        t1 = latch_cyc;
        run_instr(16'h10FF, 0, 0, 0, 2'b00, 1);
        t2 = latch_cyc;
        check("seq_pc3", pc_o, 8'h03);
        check("seq_period_a", t1 - t0, 4);
        check("seq_period_b", t2 - t1, 4);

        // Jump
        jump_to(5);
        run_instr(16'hB02A, 0, 1, 0, 2'b10, 0);
        check("jmp_pc", pc_o, 8'h2A);
        check("jmp_addr", imem_addr_o, 8'h2A);

        // Branch taken / not taken
        jump_to(8'h10);
        run_instr(16'hC0FC, 0, 0, 1, 2'b01, 1);
        check("br_taken", pc_o, 8'h0D);
        jump_to(8'h10);
        run_instr(16'hC0FC, 0, 0, 1, 2'b01, 0);
        check("br_not_taken", pc_o, 8'h11);

        // Wrap-around
        jump_to(8'hFF);
        run_instr(16'h1000, 0, 0, 0, 2'b00, 0);
        check("wrap_inc", pc_o, 8'h00);
        jump_to(8'hFE);
        run_instr(16'hC003, 0, 0, 1, 2'b01, 1);
        check("wrap_br", pc_o, 8'h02);

        // Memory stall
        run_instr(16'h2000, 5, 0, 0, 2'b00, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
`ifdef PC_FETCH_HALT_EN
            if (w[15:12] == 4'hF) w[15:12] = 4'h7;
`endif
            ucp = ($urandom_range(0, 2) == 0);
            ccp = 1'($urandom);
            src = 2'($urandom_range(0, 3));
            run_instr(w, $urandom_range(0, 3), ucp, ccp, src, 1'($urandom));
        end

        // Opcode 4'b1111
        jump_to(3);
`ifdef PC_FETCH_HALT_EN
        fetch_phase(16'hF000, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_flag", halted_o, 1'b1);
            check("halt_pc", pc_o, 8'h03);
            check("halt_req", imem_req_o, 1'b0);
            check("halt_ivalid", instr_valid_o, 1'b0);
        end
        do_reset();
        check("unhalt_flag", halted_o, 1'b0);
`else
        run_instr(16'hF000, 0, 0, 0, 2'b00, 0);
        check("nop_pc", pc_o, 8'h04);
`endif

        // Reset asserted in WAIT_CTL
        jump_to(8'h33);
        fetch_phase(16'h1111, 0);
        @(negedge clk);
        check("pre_rst_ivalid", instr_valid_o, 1'b1);
        do_reset();
        run_instr(16'h3000, 1, 0, 0, 2'b00, 0);
        check("post_rst_pc", pc_o, 8'h01);
        run_instr(16'hC002, 0, 1, 1, 2'b01, 0);
        check("post_rst_br", pc_o, 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
